core_report_arbiter: RTL and testbench

- Collects the single-cycle register-report pulses that each RISC-V core emits on its to-peripheral channel and buffers them in one small FIFO per core.
- Merges the buffered reports round-robin onto one valid/ready output channel toward the shared host/peripheral interface.
- Sits between a multi-core array and the single report sink.
- Cores cannot be stalled, so full FIFOs drop the report and flag it.

---
 rtl/core_report_arbiter.sv | 170 +++++++++++++++++
 tb/tb_core_report_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_report_arbiter.sv
// core_report_arbiter
//   Buffers single-cycle report pulses from each core in a small per-core
//   FIFO and merges them round-robin onto one valid/ready output channel.
//   Cores cannot be stalled: a pulse arriving at a full FIFO is dropped and
//   flagged in a sticky per-core overflow bit.
//   Optional: define REPORT_ARB_OVF_COUNT_EN to build the saturating
//   drop counter behind overflow_count (tied to 0 otherwise).
//
//   state | meaning
//   ------+-----------------------------------------------
//   EMPTY | output register holds nothing (out_valid = 0)
//   HOLD  | output register holds a report (out_valid = 1)
module core_report_arbiter #(
    parameter int NUM_CORES  = 4,
    parameter int CORE_BITS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            in_valid,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CORES*2-1:0]          in_type,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [1:0]                      out_type,
    output logic [CORE_BITS-1:0]            out_core,
    output logic [NUM_CORES-1:0]            overflow,
    output logic [15:0]                     overflow_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
    localparam int AW    = PTR_W - 1;
    localparam int ENT_W = DATA_WIDTH + 2;

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t                state, state_next;
    logic [ENT_W-1:0]      fifo_mem [NUM_CORES][FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr [NUM_CORES];
    logic [PTR_W-1:0]      rd_ptr [NUM_CORES];
    logic [NUM_CORES-1:0]  fifo_empty, fifo_full, push, pop, drop;
    logic                  loadable, hit;
    logic [CORE_BITS-1:0]  last_grant, grant_idx;
    logic [ENT_W-1:0]      grant_entry;

    // FIFO status: the extra pointer MSB separates full from empty
    always_comb begin
        fifo_empty = '0;
        fifo_full  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            fifo_empty[i] = (wr_ptr[i] == rd_ptr[i]);
            fifo_full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                            (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
        end
    end

    // Round-robin scan starting just after the last granted core
    always_comb begin
        int                   cand;
        logic [CORE_BITS-1:0] cand_idx;
        hit       = 1'b0;
        grant_idx = last_grant;
        cand      = 0;
        cand_idx  = '0;
        for (int off = 1; off <= NUM_CORES; off++) begin
            cand     = (int'(last_grant) + off) % NUM_CORES;
            cand_idx = CORE_BITS'(cand);
            if (!hit && !fifo_empty[cand_idx]) begin
                hit       = 1'b1;
                grant_idx = cand_idx;
            end
        end
        grant_entry = fifo_mem[grant_idx][rd_ptr[grant_idx][AW-1:0]];
    end

    // Pop/push/drop decisions; a full FIFO popped this cycle still accepts
    always_comb begin
        loadable = (state == EMPTY) || out_ready;
        pop  = '0;
        push = '0;
        drop = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            pop[i]  = loadable && hit && (grant_idx == CORE_BITS'(i));
            push[i] = in_valid[i] && (!fifo_full[i] || pop[i]);
            drop[i] = in_valid[i] && fifo_full[i] && !pop[i];
        end
    end

    // FIFO pointers; natural wrap modulo 2*FIFO_DEPTH
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (reset) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end else begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
            end
        end
    end

    // FIFO storage, not cleared by reset
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (push[i] && !reset)
                fifo_mem[i][wr_ptr[i][AW-1:0]] <=
                    {in_type[i*2 +: 2], in_data[i*DATA_WIDTH +: DATA_WIDTH]};
        end
    end

    // Output state register
    always_ff @(posedge clock) begin
        if (reset) state <= EMPTY;
        else       state <= state_next;
    end

    // Next state: reload whenever the output slot is free or being consumed
    always_comb begin
        state_next = state;
        if (loadable) state_next = hit ? HOLD : EMPTY;
    end

    assign out_valid = (state == HOLD);

    // Output payload and arbitration pointer
    always_ff @(posedge clock) begin
        if (reset) begin
            out_data   <= '0;
            out_type   <= '0;
            out_core   <= '0;
            last_grant <= CORE_BITS'(NUM_CORES - 1);
        end else if (loadable && hit) begin
            out_data   <= grant_entry[DATA_WIDTH-1:0];
            out_type   <= grant_entry[ENT_W-1 -: 2];
            out_core   <= grant_idx;
            last_grant <= grant_idx;
        end
    end

    // Sticky per-core drop flags
    always_ff @(posedge clock) begin
        if (reset) overflow <= '0;
        else       overflow <= overflow | drop;
    end

`ifdef REPORT_ARB_OVF_COUNT_EN
    logic [4:0]  drop_cnt;
    logic [16:0] count_sum;

    // Drops this cycle added to the running total, saturating
    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++)
            drop_cnt = drop_cnt + {4'b0, drop[i]};
        count_sum = {1'b0, overflow_count} + {12'b0, drop_cnt};
    end

    // Saturating drop counter
    always_ff @(posedge clock) begin
        if (reset)             overflow_count <= '0;
        else if (count_sum[16]) overflow_count <= 16'hFFFF;
        else                   overflow_count <= count_sum[15:0];
    end
`else
    assign overflow_count = '0;
`endif

endmodule

// File: tb/tb_core_report_arbiter.sv
// Directed bench for core_report_arbiter (4 cores, depth-4 FIFOs).
module tb_core_report_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [7:0]   in_type;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_type;
    logic [1:0]   out_core;
    logic [3:0]   overflow;
    logic [15:0]  overflow_count;

    int total = 0;
    int bad   = 0;

`ifdef REPORT_ARB_OVF_COUNT_EN
    localparam logic [15:0] OVF_ONE = 16'd1;
`else
    localparam logic [15:0] OVF_ONE = 16'd0;
`endif

    core_report_arbiter #(
        .NUM_CORES(4), .CORE_BITS(2), .DATA_WIDTH(32), .FIFO_DEPTH(4)
    ) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_type(in_type), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_type(out_type), .out_core(out_core),
        .overflow(overflow), .overflow_count(overflow_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = '0; in_data = '0; in_type = '0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({out_valid, out_core, out_type, out_data} !== 37'd0) begin
            bad++; $display("FAIL reset_out got v=%b c=%0d t=%0d d=%h exp all zero",
                            out_valid, out_core, out_type, out_data);
        end
        total++;
        if (overflow !== 4'b0 || overflow_count !== 16'd0) begin
            bad++; $display("FAIL reset_ovf got %b/%0d exp 0000/0", overflow, overflow_count);
        end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        in_valid = 4'b0100; in_data[64 +: 32] = 32'hDEAD_BEEF; in_type[4 +: 2] = 2'b00;
        tick();
        in_valid = '0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL single_t1 got out_valid=%b exp 0", out_valid);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_core !== 2'd2 || out_data !== 32'hDEAD_BEEF || out_type !== 2'b00) begin
            bad++; $display("FAIL single_t2 got v=%b c=%0d d=%h t=%0d exp 1/2/deadbeef/0",
                            out_valid, out_core, out_data, out_type);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL single_once got out_valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            in_valid = 4'b1111;
            for (int i = 0; i < 4; i++) begin
                in_data[i*32 +: 32] = 32'(i + 16*b);
                in_type[i*2 +: 2]   = 2'(3 - i);
            end
            tick();
            in_valid = '0;
            for (int k = 0; k < 4; k++) begin
                tick();
                total++;
                if (out_valid !== 1'b1 || out_core !== 2'(k) || out_data !== 32'(k + 16*b) ||
                    out_type !== 2'(3 - k)) begin
                    bad++; $display("FAIL rr_b%0d_k%0d got v=%b c=%0d d=%0d t=%0d exp 1/%0d/%0d/%0d",
                                    b, k, out_valid, out_core, out_data, out_type, k, k + 16*b, 3 - k);
                end
            end
            tick();
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL rr_drain_b%0d got out_valid=%b exp 0", b, out_valid);
            end
        end
    endtask

    task automatic test_stall();
        int unstable = 0;
        do_reset();
        in_valid = 4'b0011;
        in_data[0 +: 32] = 32'hAAAA_0000; in_data[32 +: 32] = 32'hBBBB_1111;
        tick();
        in_valid = '0;
        tick();
        for (int k = 0; k < 10; k++) begin
            if (out_valid !== 1'b1 || out_core !== 2'd0 || out_data !== 32'hAAAA_0000) unstable++;
            tick();
        end
        total++;
        if (unstable != 0 || out_data !== 32'hAAAA_0000) begin
            bad++; $display("FAIL stall_hold got %0d unstable cycles, d=%h exp 0/aaaa0000",
                            unstable, out_data);
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_core !== 2'd1 || out_data !== 32'hBBBB_1111) begin
            bad++; $display("FAIL stall_next got v=%b c=%0d d=%h exp 1/1/bbbb1111",
                            out_valid, out_core, out_data);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            in_valid = 4'b0010; in_data[32 +: 32] = 32'(100 + k);
            tick();
            if (k == 5) begin
                total++;
                if (overflow !== 4'b0000) begin
                    bad++; $display("FAIL ovf_early got %b exp 0000", overflow);
                end
            end
        end
        in_valid = '0;
        total++;
        if (overflow !== 4'b0010) begin
            bad++; $display("FAIL ovf_flag got %b exp 0010", overflow);
        end
        total++;
        if (overflow_count !== OVF_ONE) begin
            bad++; $display("FAIL ovf_count got %0d exp %0d", overflow_count, OVF_ONE);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'(100 + k)) begin
                bad++; $display("FAIL ovf_order_%0d got v=%b d=%0d exp 1/%0d", k, out_valid, out_data, 100 + k);
            end
            tick();
        end
        total++;
        if (out_valid !== 1'b0 || overflow !== 4'b0010) begin
            bad++; $display("FAIL ovf_end got v=%b ovf=%b exp 0/0010", out_valid, overflow);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            in_valid = 4'b0001; in_data[0 +: 32] = 32'(k);
            tick();
        end
        out_ready = 1'b1;
        in_valid = 4'b0001; in_data[0 +: 32] = 32'd6;
        tick();
        in_valid = '0;
        total++;
        if (overflow !== 4'b0000 || overflow_count !== 16'd0) begin
            bad++; $display("FAIL fullpop_ovf got %b/%0d exp 0000/0", overflow, overflow_count);
        end
        for (int k = 2; k <= 6; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'(k)) begin
                bad++; $display("FAIL fullpop_order_%0d got v=%b d=%0d exp 1/%0d", k, out_valid, out_data, k);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        do_reset();
        in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'(200 + i);
        tick();
        for (int k = 0; k < 4; k++) begin
            in_valid = 4'b1000;
            tick();
        end
        in_valid = '0;
        total++;
        if (out_valid !== 1'b1 || overflow !== 4'b1000) begin
            bad++; $display("FAIL mid_pre got v=%b ovf=%b exp 1/1000", out_valid, overflow);
        end
        reset = 1'b1; in_valid = 4'b1111;
        tick();
        total++;
        if (out_valid !== 1'b0 || overflow !== 4'b0000 || overflow_count !== 16'd0) begin
            bad++; $display("FAIL mid_reset got v=%b ovf=%b cnt=%0d exp 0/0000/0",
                            out_valid, overflow, overflow_count);
        end
        reset = 1'b0; in_valid = '0; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid !== 1'b0) stale++;
        end
        total++;
        if (stale != 0) begin
            bad++; $display("FAIL mid_stale got %0d stale cycles exp 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
